// File: rtl/ccsds123_sa_encoder_if.sv
// Interface between the residual source, the sample-adaptive encoder and the downstream bit packer.
// The master side drives residuals and consumes codewords. The encoder sits on the slave side.
interface ccsds123_sa_encoder_if #(
  parameter int D     = 16,
  parameter int UMAX  = 9,
  parameter int W_LEN = $clog2(UMAX + D + 1)
) ();

  logic [D-1:0]      res;
  logic              res_valid;
  logic [UMAX+D-1:0] code;
  logic [W_LEN-1:0]  code_len;
  logic              code_valid;
  logic              code_last;

  modport master (
    output res, res_valid,
    input  code, code_len, code_valid, code_last
  );

  modport slave (
    input  res, res_valid,
    output code, code_len, code_valid, code_last
  );

endinterface

// File: rtl/ccsds123_sa_encoder.sv
// Sample-adaptive entropy coder for mapped prediction residuals arriving in BIP order.
// Each band keeps an accumulator (sigma) and a counter (gamma) that together choose the
// Golomb-power-of-two parameter k for that band.
// Stage 1 reads and updates the band state and latches k.
// Stage 2 builds the right-aligned codeword and its bit length.
module ccsds123_sa_encoder #(
  parameter int D             = 16,
  parameter int NX            = 4,
  parameter int NY            = 4,
  parameter int NZ            = 16,
  parameter int KZ_PRIME      = 8,
  parameter int COUNTER_SIZE  = 8,
  parameter int INITIAL_COUNT = 6,
  parameter int UMAX          = 9,
  parameter int W_LEN         = $clog2(UMAX + D + 1)
) (
  input  logic                   clk,
  input  logic                   aresetn,
  ccsds123_sa_encoder_if.slave   enc
);

  localparam int CW   = UMAX + D;
  localparam int NPIX = NX * NY;
  localparam int ZW   = (NZ > 1) ? $clog2(NZ) : 1;
  localparam int PW   = (NPIX > 1) ? $clog2(NPIX) : 1;
  localparam int SW   = COUNTER_SIZE + D;
  localparam int GW   = COUNTER_SIZE;
  localparam int KW   = $clog2(D);
  localparam int XW   = SW + 2;

  // Initial accumulator: floor((3*2^(K'+6) - 49) * 2^gamma0 / 2^7)
  localparam logic [63:0]   SIGMA_INIT_W = (((64'd3 << (KZ_PRIME + 6)) - 64'd49) *
                                            (64'd1 << INITIAL_COUNT)) >> 7;
  localparam logic [SW-1:0] SIGMA_INIT   = SIGMA_INIT_W[SW-1:0];
  localparam logic [GW-1:0] GAMMA_INIT   = GW'(1 << INITIAL_COUNT);
  localparam logic [GW-1:0] GAMMA_MAX    = {GW{1'b1}};

  // Per-band adaptive state; every band is rewritten on its first pixel, so no reset is needed
  logic [SW-1:0] sigma_mem [NZ];
  logic [GW-1:0] gamma_mem [NZ];

  logic [ZW-1:0] z_reg;
  logic [PW-1:0] pix_reg;

  logic          first;
  logic          last;
  logic [SW-1:0] sigma_rd;
  logic [SW-1:0] sigma_next;
  logic [GW-1:0] gamma_rd;
  logic [GW-1:0] gamma_next;
  logic [GW+5:0] g49;
  logic [XW-1:0] t_val;
  logic [XW-1:0] g_ext;
  logic [D-2:0]  fits;
  logic [KW-1:0] k_next;

  logic          v1_reg;
  logic [D-1:0]  d_reg;
  logic [KW-1:0] k_reg;
  logic          first_reg;
  logic          last_s1_reg;

  logic [D-1:0]     u_val;
  logic [D-1:0]     low_mask;
  logic [CW-1:0]    code_next;
  logic [W_LEN-1:0] len_next;

  logic [CW-1:0]    code_reg;
  logic [W_LEN-1:0] len_reg;
  logic             code_valid_reg;
  logic             code_last_reg;

  assign first    = (pix_reg == '0);
  assign last     = (z_reg == ZW'(NZ - 1)) && (pix_reg == PW'(NPIX - 1));
  assign sigma_rd = sigma_mem[z_reg];
  assign gamma_rd = gamma_mem[z_reg];

  // T = sigma + floor(49*gamma / 128); 49 < 64, so six extra bits hold the product
  assign g49   = {6'd0, gamma_rd} * (GW + 6)'(49);
  assign t_val = XW'(sigma_rd) + XW'(g49 >> 7);
  assign g_ext = XW'(gamma_rd);

  // One comparator per candidate k: gamma * 2^k <= T
  genvar gi;
  generate
    for (gi = 0; gi < D - 1; gi++) begin : g_fit
      assign fits[gi] = ((g_ext << gi) <= t_val);
    end
  endgenerate

  // Pick the largest fitting k; when 2*gamma > T (fits[1] low), k stays 0
  always_comb begin
    k_next = '0;
    if (fits[1]) begin
      for (int j = 1; j < D - 1; j++) begin
        if (fits[j]) k_next = KW'(j);
      end
    end
  end

  // New band state: initial values on the first pixel, otherwise accumulate or halve
  always_comb begin
    logic [SW:0] acc_sum;
    logic [GW:0] g_inc;
    acc_sum    = {1'b0, sigma_rd} + (SW + 1)'(enc.res);
    g_inc      = {1'b0, gamma_rd} + (GW + 1)'(1);
    sigma_next = SIGMA_INIT;
    gamma_next = GAMMA_INIT;
    if (!first) begin
      if (gamma_rd < GAMMA_MAX) begin
        sigma_next = acc_sum[SW-1:0];
        gamma_next = g_inc[GW-1:0];
      end else begin
        sigma_next = SW'((acc_sum + (SW + 1)'(1)) >> 1);
        gamma_next = g_inc[GW:1];
      end
    end
  end

  // Band/pixel position; both wrap to zero after the last sample of an image
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      z_reg   <= '0;
      pix_reg <= '0;
    end else if (enc.res_valid) begin
      if (z_reg == ZW'(NZ - 1)) begin
        z_reg   <= '0;
        pix_reg <= last ? '0 : pix_reg + PW'(1);
      end else begin
        z_reg <= z_reg + ZW'(1);
      end
    end
  end

  // Band state write-back; it lands at the same edge, ahead of the next read of that band
  always_ff @(posedge clk) begin
    if (enc.res_valid && aresetn) begin
      sigma_mem[z_reg] <= sigma_next;
      gamma_mem[z_reg] <= gamma_next;
    end
  end

  // Stage 1 pipeline register: residual, chosen k and position flags
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      v1_reg      <= 1'b0;
      d_reg       <= '0;
      k_reg       <= '0;
      first_reg   <= 1'b0;
      last_s1_reg <= 1'b0;
    end else begin
      v1_reg <= enc.res_valid;
      if (enc.res_valid) begin
        d_reg       <= enc.res;
        k_reg       <= k_next;
        first_reg   <= first;
        last_s1_reg <= last;
      end
    end
  end

  // Codeword formation: uncoded on first pixel, escape when the unary part reaches UMAX
  always_comb begin
    u_val     = d_reg >> k_reg;
    low_mask  = (D'(1) << k_reg) - D'(1);
    code_next = CW'(d_reg);
    len_next  = W_LEN'(D);
    if (!first_reg) begin
      if (u_val < D'(UMAX)) begin
        code_next = (CW'(1) << k_reg) | CW'(d_reg & low_mask);
        len_next  = W_LEN'(u_val) + W_LEN'(k_reg) + W_LEN'(1);
      end else begin
        len_next = W_LEN'(UMAX + D);
      end
    end
  end

  // Stage 2 output register
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      code_reg       <= '0;
      len_reg        <= '0;
      code_valid_reg <= 1'b0;
      code_last_reg  <= 1'b0;
    end else begin
      code_valid_reg <= v1_reg;
      code_last_reg  <= v1_reg & last_s1_reg;
      if (v1_reg) begin
        code_reg <= code_next;
        len_reg  <= len_next;
      end
    end
  end

  assign enc.code       = code_reg;
  assign enc.code_len   = len_reg;
  assign enc.code_valid = code_valid_reg;
  assign enc.code_last  = code_last_reg;

endmodule

// File: tb/tb_ccsds123_sa_encoder.sv
// Self-checking bench for ccsds123_sa_encoder.
// Two instances share the same stimulus: a 4x4x16 image and a 16x16x16 image.
// A behavioural model predicts every codeword.
module tb_ccsds123_sa_encoder;

  localparam int D    = 16;
  localparam int UMAX = 9;
  localparam int NZ   = 16;
  localparam int KZ   = 8;
  localparam int IC   = 6;
  localparam int WL   = $clog2(UMAX + D + 1);
  localparam int CWD  = UMAX + D;

  logic clk     = 1'b0;
  logic aresetn = 1'b1;
  int   cyc     = 0;

  always #5 clk = ~clk;

  // Free-running edge counter used to measure latency
  always @(posedge clk) cyc <= cyc + 1;

  ccsds123_sa_encoder_if #(.D(D), .UMAX(UMAX)) ia ();
  ccsds123_sa_encoder_if #(.D(D), .UMAX(UMAX)) ib ();

  ccsds123_sa_encoder #(
    .D(D), .NX(4), .NY(4), .NZ(NZ), .KZ_PRIME(KZ), .COUNTER_SIZE(8),
    .INITIAL_COUNT(IC), .UMAX(UMAX), .W_LEN(WL)
  ) dut_a (
    .clk(clk), .aresetn(aresetn), .enc(ia.slave)
  );

  ccsds123_sa_encoder #(
    .D(D), .NX(16), .NY(16), .NZ(NZ), .KZ_PRIME(KZ), .COUNTER_SIZE(8),
    .INITIAL_COUNT(IC), .UMAX(UMAX), .W_LEN(WL)
  ) dut_b (
    .clk(clk), .aresetn(aresetn), .enc(ib.slave)
  );

  typedef struct {
    logic [CWD-1:0] code;
    int             len;
    bit             last;
    int             cyc;
  } exp_t;

  exp_t   q0[$];
  exp_t   q1[$];
  longint msig [2][NZ];
  int     mgam [2][NZ];
  int     mn [2];
  int     img [2] = '{256, 4096};
  int     out_cnt [2];
  int     in_cnt;
  int     checks = 0;
  int     errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  // Reference model: position from a flat sample index, k from the threshold rule
  task automatic model(input int i, input int delta, input int c, output exp_t e);
    int     band, pix, k, u;
    longint t;
    band   = mn[i] % NZ;
    pix    = mn[i] / NZ;
    e.cyc  = c;
    e.last = (mn[i] == img[i] - 1);
    if (pix == 0) begin
      e.code = CWD'(delta);
      e.len  = D;
      msig[i][band] = ((3 * (longint'(1) << (KZ + 6)) - 49) * (longint'(1) << IC)) / 128;
      mgam[i][band] = 2 ** IC;
    end else begin
      t = msig[i][band] + (49 * mgam[i][band]) / 128;
      k = 0;
      if (2 * mgam[i][band] <= t) begin
        for (int kk = 0; kk <= D - 2; kk++) begin
          if ((longint'(mgam[i][band]) << kk) <= t) k = kk;
        end
      end
      u = delta >> k;
      if (u < UMAX) begin
        e.code = CWD'((1 << k) + (delta % (1 << k)));
        e.len  = u + 1 + k;
      end else begin
        e.code = CWD'(delta);
        e.len  = UMAX + D;
      end
      if (mgam[i][band] < 255) begin
        msig[i][band] = msig[i][band] + delta;
        mgam[i][band] = mgam[i][band] + 1;
      end else begin
        msig[i][band] = (msig[i][band] + delta + 1) / 2;
        mgam[i][band] = (mgam[i][band] + 1) / 2;
      end
      chk("sigma_range", (msig[i][band] < (longint'(1) << 24)), 1);
      if (i == 1 && band == 0 && pix == 192) chk("rescale_gamma", mgam[i][band], 128);
    end
    mn[i] = (mn[i] + 1) % img[i];
  endtask

  task automatic check_out(input int i, input logic cv, input logic cl,
                           input logic [CWD-1:0] c, input logic [WL-1:0] l);
    exp_t e;
    int   qs;
    qs = (i == 0) ? q0.size() : q1.size();
    if (cv === 1'b1) begin
      if (qs == 0) begin
        chk($sformatf("unexpected_valid_%0d", i), cv, 0);
      end else begin
        if (i == 0) e = q0.pop_front();
        else        e = q1.pop_front();
        out_cnt[i]++;
        $display("out%0d #%0d code=%0h len=%0d last=%0b", i, out_cnt[i], c, l, cl);
        chk($sformatf("code_%0d", i), c, e.code);
        chk($sformatf("len_%0d", i), l, e.len);
        chk($sformatf("last_%0d", i), cl, e.last);
        chk($sformatf("last_by_count_%0d", i), cl, (out_cnt[i] % img[i]) == 0);
        chk($sformatf("latency_%0d", i), cyc - e.cyc, 2);
      end
    end else begin
      chk($sformatf("last_without_valid_%0d", i), cl, 0);
      if (qs > 0) begin
        e = (i == 0) ? q0[0] : q1[0];
        if (cyc - e.cyc >= 2) begin
          chk($sformatf("missing_valid_%0d", i), cv, 1);
          if (i == 0) void'(q0.pop_front());
          else        void'(q1.pop_front());
        end
      end
    end
  endtask

  // One clock of stimulus; optional hand-computed code/len overrides the model for instance A
  task automatic step(input bit v, input int d, input bit hand, input int hcode, input int hlen);
    exp_t e;
    @(negedge clk);
    ia.res_valid = v;
    ia.res       = d[D-1:0];
    ib.res_valid = v;
    ib.res       = d[D-1:0];
    if (v) begin
      model(0, d, cyc, e);
      if (hand) begin
        e.code = CWD'(hcode);
        e.len  = hlen;
      end
      q0.push_back(e);
      model(1, d, cyc, e);
      q1.push_back(e);
      in_cnt++;
    end
    @(posedge clk);
    #1;
    check_out(0, ia.code_valid, ia.code_last, ia.code, ia.code_len);
    check_out(1, ib.code_valid, ib.code_last, ib.code, ib.code_len);
  endtask

  task automatic do_reset();
    aresetn = 1'b0;
    #1;
    chk("rst_code_a", ia.code, 0);
    chk("rst_len_a", ia.code_len, 0);
    chk("rst_valid_a", ia.code_valid, 0);
    chk("rst_last_a", ia.code_last, 0);
    chk("rst_code_b", ib.code, 0);
    chk("rst_len_b", ib.code_len, 0);
    chk("rst_valid_b", ib.code_valid, 0);
    chk("rst_last_b", ib.code_last, 0);
    q0.delete();
    q1.delete();
    mn[0] = 0;
    mn[1] = 0;
    out_cnt[0] = 0;
    out_cnt[1] = 0;
    in_cnt = 0;
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    @(negedge clk);
    aresetn = 1'b1;
  endtask

  function automatic int rand_delta();
    if ($urandom_range(0, 3) == 0) return int'($urandom_range(0, 65535));
    return int'($urandom_range(0, 1500));
  endfunction

  initial begin
    int d;
    int acc;
    ia.res_valid = 1'b0;
    ia.res       = '0;
    ib.res_valid = 1'b0;
    ib.res       = '0;
    #2;
    do_reset();

    // First pixel: all bands uncoded
    for (int b = 0; b < NZ; b++) step(1, 16'h1234, 1, 16'h1234, 16);
    // Band 0 pix 1: normal code with k=8
    step(1, 300, 1, 300, 10);
    // Band 1 pix 1 (same initial state): escape
    step(1, 5000, 1, 5000, 25);

    // Random residuals with 2/3 idle cycles across two full images of instance A
    acc = 18;
    while (acc < 512) begin
      if ($urandom_range(0, 2) == 0) begin
        d = rand_delta();
        if (acc >= 256 && acc < 256 + NZ) step(1, d, 1, d, 16);
        else                              step(1, d, 0, 0, 0);
        acc++;
      end else begin
        step(0, 0, 0, 0, 0);
      end
    end
    for (int n = 0; n < 4; n++) step(0, 0, 0, 0, 0);
    chk("out_count_a", out_cnt[0], in_cnt);
    chk("out_count_b", out_cnt[1], in_cnt);

    // Reset mid-image with samples still in flight
    do_reset();
    for (int n = 0; n < 37; n++) step(1, rand_delta(), 0, 0, 0);
    do_reset();
    d = rand_delta();
    step(1, d, 1, d, 16);
    for (int n = 0; n < 4; n++) step(0, 0, 0, 0, 0);
    chk("post_reset_count_a", out_cnt[0], 1);

    // Rescale: zero residuals over a full 16x16 image of instance B
    do_reset();
    for (int n = 0; n < 4096; n++) step(1, 0, 0, 0, 0);
    for (int n = 0; n < 4; n++) step(0, 0, 0, 0, 0);
    chk("rescale_count_b", out_cnt[1], 4096);
    chk("rescale_count_a", out_cnt[0], 4096);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
